// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers an A/B matrix pair and replays it as skewed operand
// streams. Define SYSTOLIC_FEEDER_DBUF_EN to add a second load bank.
module systolic_feeder #(
    parameter int DIN_WIDTH = 8,
    parameter int N         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0][DIN_WIDTH-1:0] ld_a_row,
    input  logic [N-1:0][DIN_WIDTH-1:0] ld_b_row,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    output logic [N-1:0][DIN_WIDTH-1:0] a_din,
    output logic [N-1:0][DIN_WIDTH-1:0] b_din,
    output logic                        in_valid,
    output logic                        busy,
    output logic                        done
);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic DUAL = 1'(NB - 1);
    localparam int TW = $clog2(2 * N);
    localparam int RW = $clog2(N);
    localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
    localparam logic [TW-1:0] D_LAST = TW'(N - 1);
    localparam logic [RW-1:0] R_LAST = RW'(N - 1);

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        DRAIN
    } state_t;

    typedef logic [N-1:0][DIN_WIDTH-1:0] row_t;

    row_t a_buf [NB][N];
    row_t b_buf [NB][N];

    state_t        state, state_n;
    logic [TW-1:0] cnt, cnt_n;
    logic [RW-1:0] row;
    logic [NB-1:0] full, set_m, clr_m, fill;
    logic          wr_bank, rd_bank, rd_n, nxt_bank;
    logic          accept, last_beat;

    // A bank stays full until its drain completes, so it cannot be reloaded
    // while its operands are still being replayed.
    assign ld_ready  = ~full[wr_bank];
    assign accept    = ld_valid & ld_ready;
    assign last_beat = accept & (row == R_LAST);
    assign nxt_bank  = rd_bank ^ DUAL;

    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (last_beat)
            set_m[wr_bank] = 1'b1;
        if (state == DRAIN && cnt == D_LAST)
            clr_m[rd_bank] = 1'b1;
        fill = (full & ~clr_m) | set_m;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_n    = rd_bank;
        unique case (state)
            LOAD: begin
                if (fill[nxt_bank]) begin
                    state_n = ISSUE;
                    cnt_n   = '0;
                    rd_n    = nxt_bank;
                end
            end
            ISSUE: begin
                if (cnt == T_LAST) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == D_LAST) begin
                    cnt_n = '0;
                    if (fill[nxt_bank]) begin
                        state_n = ISSUE;
                        rd_n    = nxt_bank;
                    end else begin
                        state_n = LOAD;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            cnt      <= '0;
            row      <= '0;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= DUAL;
            a_din    <= '0;
            b_din    <= '0;
            in_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rd_bank <= rd_n;
            full    <= fill;
            if (accept)
                row <= last_beat ? '0 : row + 1'b1;
            if (last_beat)
                wr_bank <= wr_bank ^ DUAL;
            in_valid <= (state_n == ISSUE);
            busy     <= (state_n != LOAD);
            done     <= (state_n == DRAIN) && (cnt_n == D_LAST);
            a_din    <= '0;
            b_din    <= '0;
            // Element (i,k) lands on row lane i and column lane k at t = i+k.
            if (state_n == ISSUE) begin
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < N; k++) begin
                        if (int'(cnt_n) == i + k) begin
                            a_din[i] <= a_buf[rd_n][i][k];
                            b_din[k] <= b_buf[rd_n][i][k];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            a_buf[wr_bank][row] <= ld_a_row;
            b_buf[wr_bank][row] <= ld_b_row;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed and random checks of systolic_feeder against
// a matrix-level reference model.
`timescale 1ns/1ps
module tb_systolic_feeder;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int NISS = 2 * N - 1;
    localparam int WIN  = 3 * N - 1;

    typedef logic [N-1:0][W-1:0] row_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    row_t ld_a_row = '0;
    row_t ld_b_row = '0;
    logic ld_valid = 1'b0;
    logic ld_ready, in_valid, busy, done;
    row_t a_din, b_din;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    systolic_feeder #(.DIN_WIDTH(W), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_a_row (ld_a_row),
        .ld_b_row (ld_b_row),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .a_din    (a_din),
        .b_din    (b_din),
        .in_valid (in_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference: pos is the cycle index inside the issue+drain window, -1 idle.
    row_t la[N], lb[N], pa[N], pb[N], ia[N], ib[N];
    int   pos  = -1;
    int   rows = 0;
    bit   pend = 1'b0;

    function automatic bit m_ready();
`ifdef SYSTOLIC_FEEDER_DBUF_EN
        return !pend;
`else
        return pos < 0;
`endif
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            pos  = -1;
            rows = 0;
            pend = 1'b0;
        end else begin
            acc = ld_valid && m_ready();
            if (pos >= 0) begin
                pos++;
                if (pos == WIN) begin
                    pos = -1;
                    if (pend) begin
                        pos  = 0;
                        ia   = pa;
                        ib   = pb;
                        pend = 1'b0;
                    end
                end
            end
            if (acc) begin
                la[rows] = ld_a_row;
                lb[rows] = ld_b_row;
                rows++;
                if (rows == N) begin
                    rows = 0;
                    if (pos < 0) begin
                        pos = 0;
                        ia  = la;
                        ib  = lb;
                    end else begin
                        pa   = la;
                        pb   = lb;
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        row_t ea, eb;
        logic ev, eby, ed, er;
        if (chk_en) begin
            ea  = '0;
            eb  = '0;
            ev  = (pos >= 0) && (pos < NISS);
            eby = (pos >= 0);
            ed  = (pos == WIN - 1);
            er  = m_ready();
            if (ev) begin
                for (int i = 0; i < N; i++)
                    for (int k = 0; k < N; k++)
                        if (i + k == pos) begin
                            ea[i] = ia[i][k];
                            eb[k] = ib[i][k];
                        end
            end
            total++;
            if (a_din !== ea || b_din !== eb) begin
                bad++;
                $display("FAIL data @%0t a_din=%h b_din=%h want a=%h b=%h",
                         $time, a_din, b_din, ea, eb);
            end
            total++;
            if ({ld_ready, in_valid, busy, done} !== {er, ev, eby, ed}) begin
                bad++;
                $display("FAIL ctrl @%0t rdy/iv/busy/done=%b%b%b%b want %b%b%b%b",
                         $time, ld_ready, in_valid, busy, done, er, ev, eby, ed);
            end
        end
    end

    row_t sa[N], sb[N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic load_pair(input int gap);
        for (int k = 0; k < N; k++) begin
            ld_a_row = sa[k];
            ld_b_row = sb[k];
            ld_valid = 1'b1;
            tick();
            ld_valid = 1'b0;
            if (k < N - 1)
                repeat (gap) tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        ld_valid = 1'b0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_wait busy", busy, 0);
    endtask

    task automatic skew_data();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                sa[i][j] = W'(4 * i + j + 1);
                sb[i][j] = (i == j) ? W'(1) : W'(0);
            end
    endtask

    task automatic skew_run(input int gap);
        int niv = 0;
        int dat = -1;
        skew_data();
        load_pair(gap);
        for (int c = 0; c < 3 * N; c++) begin
            if (c == 0) begin
                chk("t0 in_valid", in_valid, 1);
                chk("t0 a_din", a_din, 32'h0000_0001);
                chk("t0 b_din", b_din, 32'h0000_0001);
            end
            if (c == 3) begin
                chk("t3 a_din", a_din, 32'h0D0A_0704);
                chk("t3 b_din", b_din, 32'h0000_0000);
            end
            if (c == 6) begin
                chk("t6 a_din", a_din, 32'h1000_0000);
                chk("t6 b_din", b_din, 32'h0100_0000);
            end
            if (in_valid)
                niv++;
            if (done && dat < 0)
                dat = c;
            tick();
        end
        chk("in_valid cycles", niv, 7);
        chk("done cycle", dat, 10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int na, nb, wa, wb, acc_early, nlow, ngap;
        logic d14, r15, iv10, iv15;

        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst ld_ready", ld_ready, 1);
        chk("rst in_valid", in_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst a_din", a_din, 0);
        chk("rst b_din", b_din, 0);
        rst = 1'b0;
        tick();

        skew_run(0);
        wait_idle();
        skew_run(3);
        wait_idle();

        for (int k = 0; k < N; k++) begin
            sa[k] = {N{8'h80}};
            sb[k] = {N{8'h7F}};
        end
        load_pair(0);
        na = 0; nb = 0; wa = 0; wb = 0;
        for (int c = 0; c < NISS; c++) begin
            for (int i = 0; i < N; i++) begin
                if (a_din[i] != 0) begin
                    na++;
                    if (a_din[i] != 8'h80) wa++;
                end
                if (b_din[i] != 0) begin
                    nb++;
                    if (b_din[i] != 8'h7F) wb++;
                end
            end
            tick();
        end
        chk("neg a lanes", na, 16);
        chk("pos b lanes", nb, 16);
        chk("neg a wrong", wa, 0);
        chk("pos b wrong", wb, 0);
        wait_idle();

`ifndef SYSTOLIC_FEEDER_DBUF_EN
        acc_early = 0; nlow = 0; d14 = 1'b0; r15 = 1'b0;
        ld_valid = 1'b1;
        for (int c = 0; c < 19; c++) begin
            ld_a_row = row_t'($urandom);
            ld_b_row = row_t'($urandom);
            if (c < 15 && ld_ready) acc_early++;
            if (!ld_ready) nlow++;
            if (c == 14) d14 = done;
            if (c == 15) r15 = ld_ready;
            tick();
        end
        ld_valid = 1'b0;
        chk("bp beats before done", acc_early, 4);
        chk("bp ready low cycles", nlow, 11);
        chk("bp done cycle", d14, 1);
        chk("bp ready after done", r15, 1);
        wait_idle();
`else
        ngap = 0; d14 = 1'b0; iv10 = 1'b0; iv15 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            ld_valid = (c < 8);
            ld_a_row = row_t'($urandom);
            ld_b_row = row_t'($urandom);
            if (c >= 11 && c <= 14 && !in_valid) ngap++;
            if (c == 10) iv10 = in_valid;
            if (c == 14) d14 = done;
            if (c == 15) iv15 = in_valid;
            tick();
        end
        ld_valid = 1'b0;
        chk("dbuf gap cycles", ngap, 4);
        chk("dbuf last issue", iv10, 1);
        chk("dbuf done", d14, 1);
        chk("dbuf reissue", iv15, 1);
        wait_idle();
`endif

        skew_data();
        load_pair(0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst in_valid", in_valid, 0);
        chk("mid rst a_din", a_din, 0);
        chk("mid rst b_din", b_din, 0);
        chk("mid rst ld_ready", ld_ready, 1);
        chk("mid rst busy", busy, 0);
        skew_run(0);
        wait_idle();

        for (int c = 0; c < 2000; c++) begin
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_a_row = row_t'($urandom);
            ld_b_row = row_t'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst      = 1'b0;
        ld_valid = 1'b0;
        repeat (3 * N) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
